// File: rtl/vram_fetch_if.sv
// vram_fetch_if: bundles the row-fetch control, VRAM read port, cell FIFO read side and
// host read port of vram_fetch. The master modport is the fetcher's view.
interface vram_fetch_if;
    logic        rowStart;
    logic [4:0]  textRow;
    logic [12:0] vramRdAddr;
    logic [7:0]  vramRdData;
    logic        cellValid;
    logic [7:0]  cellChar;
    logic [7:0]  cellAttr;
    logic        cellRd;
    logic        rowDone;
    logic        hostRdReq;
    logic [12:0] hostRdAddr;
    logic [7:0]  hostRdData;
    logic        hostRdAck;

    modport master (
        input  rowStart, textRow, vramRdData, cellRd, hostRdReq, hostRdAddr,
        output vramRdAddr, cellValid, cellChar, cellAttr, rowDone, hostRdData, hostRdAck
    );

    modport slave (
        output rowStart, textRow, vramRdData, cellRd, hostRdReq, hostRdAddr,
        input  vramRdAddr, cellValid, cellChar, cellAttr, rowDone, hostRdData, hostRdAck
    );
endinterface

// File: rtl/vram_fetch.sv
// vram_fetch: display-side reader for the 80x30 text-mode VRAM. Fetches one text row of
// char/attr pairs into a 2-entry cell FIFO and, when the macro VRAM_FETCH_HOST_EN is
// defined, interleaves host reads into free read slots. Without the macro the host port
// is inert (ack and data tied to 0).
module vram_fetch #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic         clk,
    input  logic         rst,
    vram_fetch_if.master bus
);

`ifdef VRAM_FETCH_HOST_EN
    typedef enum logic [1:0] {StIdle, StChar, StAttr, StHost} state_t;
`else
    typedef enum logic [1:0] {StIdle, StChar, StAttr} state_t;
`endif

    state_t      state, nextState;
    logic        rowActive;
    logic [6:0]  col;          // next column to fetch
    logic [12:0] rowBase;
    logic [12:0] rdAddr;
    logic        capChar;      // char byte on vramRdData this cycle
    logic        capAttr;      // attr byte on vramRdData this cycle -> push
    logic        capLast;      // the pending push is the last cell of the row
    logic [7:0]  charByte;
    logic [15:0] fifoMem [2];
    logic        wrPtr, rdPtr;
    logic [1:0]  count;        // FIFO occupancy
    logic [1:0]  reserved;     // cells issued but not yet pushed
    logic        rowDoneQ;

    logic        flush, rowValid, pop, slotFree, hostPending, issueChar, lastCell;
    logic [6:0]  colNext, fetchCol;
    logic [12:0] newBase, charAddr;

    assign flush    = bus.rowStart;
    assign rowValid = 32'(bus.textRow) < ROWS;
    // Flush wins over a coincident pop.
    assign pop      = bus.cellRd && (count != 2'd0) && !flush;
    // A pop this cycle already frees its slot for the next issue decision.
    assign slotFree = ({1'b0, count} + {1'b0, reserved} - {2'b0, pop}) < 3'd2;
    assign colNext  = col + 7'd1;
    assign lastCell = 32'(colNext) == COLS;
    // Leaving ATTR the column advances in the same edge, so fetch the next one.
    assign fetchCol = (state == StAttr) ? colNext : col;
    // textRow * 160 = textRow * 128 + textRow * 32
    assign newBase  = {1'b0, bus.textRow, 7'b0} + {3'b0, bus.textRow, 5'b0};
    assign charAddr = rowBase + {5'b0, fetchCol, 1'b0};
    assign issueChar = (nextState == StChar);

    assign bus.vramRdAddr = rdAddr;
    assign bus.cellValid  = (count != 2'd0);
    assign bus.cellChar   = fifoMem[rdPtr][15:8];
    assign bus.cellAttr   = fifoMem[rdPtr][7:0];
    assign bus.rowDone    = rowDoneQ;

`ifdef VRAM_FETCH_HOST_EN
    logic       capHost;
    logic       hostAck;
    logic [7:0] hostData;

    // Pending means requested and neither being read, captured nor acknowledged.
    assign hostPending = bus.hostRdReq && (state != StHost) && !capHost && !hostAck;
    assign bus.hostRdAck  = hostAck;
    assign bus.hostRdData = hostData;

    // Host read capture: data arrives the cycle after HOST, ack one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            capHost  <= 1'b0;
            hostAck  <= 1'b0;
            hostData <= 8'h00;
        end else begin
            capHost <= (state == StHost);
            hostAck <= capHost;
            if (capHost) begin
                hostData <= bus.vramRdData;
            end
        end
    end
`else
    logic unusedHost;

    assign unusedHost     = bus.hostRdReq ^ (^bus.hostRdAddr);
    assign hostPending    = 1'b0;
    assign bus.hostRdAck  = 1'b0;
    assign bus.hostRdData = 8'h00;
`endif

    // Read-slot arbitration: a char/attr pair is never split by a host read.
    always_comb begin
        nextState = state;
        unique case (state)
            StIdle: begin
                if (hostPending) begin
`ifdef VRAM_FETCH_HOST_EN
                    nextState = StHost;
`endif
                end else if (rowActive && slotFree) begin
                    nextState = StChar;
                end
            end
            StChar: nextState = StAttr;
            StAttr: begin
                if (hostPending) begin
`ifdef VRAM_FETCH_HOST_EN
                    nextState = StHost;
`endif
                end else if (rowActive && !lastCell && slotFree) begin
                    nextState = StChar;
                end else begin
                    nextState = StIdle;
                end
            end
`ifdef VRAM_FETCH_HOST_EN
            StHost: nextState = (rowActive && slotFree) ? StChar : StIdle;
`endif
            default: nextState = StIdle;
        endcase
        // A new row abandons any half-issued pair.
        if (flush) begin
            nextState = StIdle;
        end
    end

    // FSM state, registered read address, data capture and cell FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            rowActive  <= 1'b0;
            col        <= 7'd0;
            rowBase    <= 13'd0;
            rdAddr     <= 13'd0;
            capChar    <= 1'b0;
            capAttr    <= 1'b0;
            capLast    <= 1'b0;
            charByte   <= 8'h00;
            fifoMem[0] <= 16'h0000;
            fifoMem[1] <= 16'h0000;
            wrPtr      <= 1'b0;
            rdPtr      <= 1'b0;
            count      <= 2'd0;
            reserved   <= 2'd0;
            rowDoneQ   <= 1'b0;
        end else begin
            state    <= nextState;
            capChar  <= (state == StChar) && !flush;
            capAttr  <= (state == StAttr) && !flush;
            capLast  <= (state == StAttr) && lastCell;
            rowDoneQ <= 1'b0;

            if (capChar) begin
                charByte <= bus.vramRdData;
            end

            if (nextState == StChar) begin
                rdAddr <= charAddr;
            end else if (nextState == StAttr) begin
                rdAddr <= rdAddr + 13'd1;
`ifdef VRAM_FETCH_HOST_EN
            end else if (nextState == StHost) begin
                rdAddr <= bus.hostRdAddr;
`endif
            end

            if (flush) begin
                rowActive <= rowValid;
                col       <= 7'd0;
                rowBase   <= newBase;
                count     <= 2'd0;
                reserved  <= 2'd0;
                wrPtr     <= 1'b0;
                rdPtr     <= 1'b0;
            end else begin
                if (state == StAttr) begin
                    col <= colNext;
                    if (lastCell) begin
                        rowActive <= 1'b0;
                    end
                end
                if (capAttr) begin
                    fifoMem[wrPtr] <= {charByte, bus.vramRdData};
                    wrPtr          <= ~wrPtr;
                    rowDoneQ       <= capLast;
                end
                if (pop) begin
                    rdPtr <= ~rdPtr;
                end
                count    <= count + {1'b0, capAttr} - {1'b0, pop};
                reserved <= reserved + {1'b0, issueChar} - {1'b0, capAttr};
            end
        end
    end

endmodule
